host_bus_arbiter: RTL

Shares one Ibex-style (req/gnt/rvalid) device-side master port between `NrHosts` hosts. It sits between the cores/debug masters and the single host port of the Wishbone crossbar wrapper. It arbitrates address phases and tracks the owner of every in-flight transaction in an ID FIFO. Each response (rvalid/rdata/err) returns only to the host that issued the request, in issue order.

---
 rtl/host_bus_arbiter_if.sv | 50 +++++
 rtl/host_bus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/host_bus_arbiter_if.sv
// host_bus_arbiter_if
// Bundles the Ibex-style (req/gnt/rvalid) signals between NrHosts upstream
// hosts and the single downstream device port of host_bus_arbiter.
//   host_req_i/host_gnt_o          per-host address-phase handshake
//   host_addr_i/we_i/be_i/wdata_i  per-host address-phase fields
//   host_rvalid_o                  per-host response valid (owner only)
//   host_rdata_o/host_err_o        per-host response data/error (broadcast)
//   dev_*                          the shared downstream master port
// Modports:
//   master - the arbiter's view (it masters the device port)
//   slave  - the surrounding environment (hosts and device)
interface host_bus_arbiter_if #(
  parameter int NrHosts   = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic [NrHosts-1:0]                  host_req_i;
  logic [NrHosts-1:0]                  host_gnt_o;
  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i;
  logic [NrHosts-1:0]                  host_we_i;
  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i;
  logic [NrHosts-1:0]                  host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]   host_rdata_o;
  logic [NrHosts-1:0]                  host_err_o;

  logic                   dev_req_o;
  logic                   dev_gnt_i;
  logic [AddrWidth-1:0]   dev_addr_o;
  logic                   dev_we_o;
  logic [DataWidth/8-1:0] dev_be_o;
  logic [DataWidth-1:0]   dev_wdata_o;
  logic                   dev_rvalid_i;
  logic [DataWidth-1:0]   dev_rdata_i;
  logic                   dev_err_i;

  modport master (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );

  modport slave (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );
endinterface

// File: rtl/host_bus_arbiter.sv
// host_bus_arbiter
// Shares one Ibex-style device master port between NrHosts hosts. Address
// phases are arbitrated combinationally; the owner of every accepted
// transaction is pushed into an in-flight ID FIFO so each response is routed
// back only to the host that issued it, in issue order.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   bus        host_bus_arbiter_if.master (host side + device side)
//   spurious_o one-cycle pulse when a response arrives with no owner
// Configuration:
//   HOST_ARB_RR_EN defined   -> round-robin arbitration starting at rr_ptr
//   HOST_ARB_RR_EN undefined -> fixed priority, lowest index wins
module host_bus_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  host_bus_arbiter_if.master   bus,
  output logic                 spurious_o
);

  localparam int IdxW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW  = $clog2(MaxOutstanding) + 1;
  localparam int Depth = 1 << PtrW;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  idx_t sel;
  idx_t lock_idx;
  logic lock;
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t count;
  idx_t fifo_mem [Depth];
  logic fifo_full;
  logic fifo_empty;
  logic dev_req;
  logic accept;
  logic rsp_valid;
  logic pop;

`ifdef HOST_ARB_RR_EN
  idx_t rr_ptr;
  int   cand;
  logic found;
`endif

  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Full is taken from the registered count only, so a pop in the same cycle
  // never re-opens the request path (keeps dev_gnt_i out of dev_req_o).
  assign fifo_full  = (count == ptr_t'(MaxOutstanding));
  assign fifo_empty = (count == '0);

  // Reset gates the combinational outputs so they drop immediately.
  assign dev_req    = rst_ni && (|bus.host_req_i) && !fifo_full;
  assign accept     = dev_req && bus.dev_gnt_i;
  assign rsp_valid  = rst_ni && bus.dev_rvalid_i;
  assign pop        = rsp_valid && !fifo_empty;
  assign spurious_o = rsp_valid && fifo_empty;

  // Host selection; a stalled request stays locked to its host until granted.
  always_comb begin
    sel = '0;
`ifdef HOST_ARB_RR_EN
    cand  = 0;
    found = 1'b0;
`endif
    if (lock) begin
      sel = lock_idx;
    end else begin
`ifdef HOST_ARB_RR_EN
      for (int k = 0; k < NrHosts; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NrHosts) cand = cand - NrHosts;
        if (!found && bus.host_req_i[idx_t'(cand)]) begin
          sel   = idx_t'(cand);
          found = 1'b1;
        end
      end
`else
      for (int h = NrHosts - 1; h >= 0; h--) begin
        if (bus.host_req_i[idx_t'(h)]) sel = idx_t'(h);
      end
`endif
    end
  end

  // Address-phase mux, grant steering and response routing.
  always_comb begin
    bus.dev_req_o     = dev_req;
    bus.dev_addr_o    = bus.host_addr_i[sel];
    bus.dev_we_o      = bus.host_we_i[sel];
    bus.dev_be_o      = bus.host_be_i[sel];
    bus.dev_wdata_o   = bus.host_wdata_i[sel];
    bus.host_gnt_o    = '0;
    bus.host_rvalid_o = '0;
    if (accept) bus.host_gnt_o[sel] = 1'b1;
    if (pop) bus.host_rvalid_o[fifo_mem[rd_ptr]] = 1'b1;
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_rdata_o[h] = bus.dev_rdata_i;
      bus.host_err_o[h]   = bus.dev_err_i;
    end
  end

  // Owner FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr] <= sel;
  end

  // Owner FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + ptr_t'(1);
        2'b01:   count <= count - ptr_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Lock and round-robin pointer bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock     <= 1'b0;
      lock_idx <= '0;
`ifdef HOST_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else if (accept) begin
      lock <= 1'b0;
`ifdef HOST_ARB_RR_EN
      rr_ptr <= (sel == idx_t'(NrHosts - 1)) ? '0 : sel + idx_t'(1);
`endif
    end else if (dev_req) begin
      lock     <= 1'b1;
      lock_idx <= sel;
    end
  end

endmodule
